// File: rtl/mips_fetch_unit_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    // Redirect targets are always word-aligned; low address bits are dropped.
    function automatic logic [FETCH_XLEN-1:0] align_pc(input logic [FETCH_XLEN-1:0] addr);
        return {addr[FETCH_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus: ICache request/response, redirect input and decode hand-off.
interface mips_fetch_unit_if #(
    parameter int XLEN = 32
) ();

    logic            fetchEn;
    logic            iCacheReqValid;
    logic            iCacheReqReady;
    logic [XLEN-1:0] iCacheReadAddr;
    logic            iCacheRespValid;
    logic [XLEN-1:0] iCacheReadData;
    logic            redirectValid;
    logic [XLEN-1:0] redirectPc;
    logic            fetchValid;
    logic            fetchReady;
    logic [XLEN-1:0] fetchInstr;
    logic [XLEN-1:0] fetchPc;

    // The fetch unit is the master of this bundle.
    modport master (
        input  fetchEn,
        output iCacheReqValid,
        input  iCacheReqReady,
        output iCacheReadAddr,
        input  iCacheRespValid,
        input  iCacheReadData,
        input  redirectValid,
        input  redirectPc,
        output fetchValid,
        input  fetchReady,
        output fetchInstr,
        output fetchPc
    );

    modport slave (
        output fetchEn,
        input  iCacheReqValid,
        output iCacheReqReady,
        input  iCacheReadAddr,
        output iCacheRespValid,
        output iCacheReadData,
        output redirectValid,
        output redirectPc,
        input  fetchValid,
        output fetchReady,
        input  fetchInstr,
        input  fetchPc
    );

endinterface

// File: rtl/mips_fetch_unit_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop.
module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: storage is reset only because the head entry is visible on
            // the outputs after reset; larger arrays would normally stay unreset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS fetch front end: owns the PC, keeps one ICache request in flight, queues
// {pc, instr} for decode. Define FETCH_PERF_EN to add the performance counters.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    mips_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perfFetchCnt,
    output logic [31:0]       perfStallCnt,
    output logic [31:0]       perfFlushCnt
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    if (XLEN != FETCH_XLEN) begin : g_bad_xlen
        $error("XLEN must equal the fetch_entry_t field width");
    end
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("QDEPTH must be a power of 2 and at least 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word-aligned");
    end

    fetch_state_t    state;
    fetch_state_t    state_nx;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nx;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_pc_nx;
    logic            req_valid;
    logic            outstanding;
    logic            credit;
    logic            fetch_valid;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    logic            q_full;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_in;
    fetch_entry_t    q_head;

    // Any state other than RUN holds one response slot that must come back.
    assign outstanding = (state != RUN);
    assign credit      = (q_count + CW'(outstanding)) < CW'(QDEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            req_pc <= req_pc_nx;
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        req_pc_nx = req_pc;
        req_valid = 1'b0;
        q_push    = 1'b0;

        case (state)
            RUN: begin
                req_valid = bus.fetchEn && credit && !bus.redirectValid && !rst;
                if (req_valid && bus.iCacheReqReady) begin
                    req_pc_nx = pc;
                    pc_nx     = pc + XLEN'(INSTR_BYTES);
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (bus.iCacheRespValid) begin
                    q_push   = !bus.redirectValid;
                    state_nx = RUN;
                end else if (bus.redirectValid) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // The stale response is swallowed whether or not a new redirect arrives.
                if (bus.iCacheRespValid) begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = RUN;
            end
        endcase

        if (bus.redirectValid) begin
            pc_nx = align_pc(bus.redirectPc);
        end
    end

    assign q_in.pc    = req_pc;
    assign q_in.instr = bus.iCacheReadData;

    // A redirect hides the head so decode cannot consume an entry being flushed.
    assign fetch_valid = !q_empty && !bus.redirectValid && !rst;
    assign q_pop       = fetch_valid && bus.fetchReady;

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_data(q_in),
        .pop      (q_pop),
        .flush    (bus.redirectValid),
        .head     (q_head),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full)
    );

    assign bus.iCacheReqValid = req_valid;
    assign bus.iCacheReadAddr = pc;
    assign bus.fetchValid     = fetch_valid;
    assign bus.fetchInstr     = q_head.instr;
    assign bus.fetchPc        = q_head.pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perfFetchCnt <= '0;
            perfStallCnt <= '0;
            perfFlushCnt <= '0;
        end else begin
            if (q_push) begin
                perfFetchCnt <= perfFetchCnt + 32'd1;
            end
            if (state == RUN && bus.fetchEn && !credit) begin
                perfStallCnt <= perfStallCnt + 32'd1;
            end
            if (bus.redirectValid) begin
                perfFlushCnt <= perfFlushCnt + 32'd1;
            end
        end
    end
`endif

    // The ICache may only answer a request that is actually in flight.
    a_no_resp_in_run: assert property (@(posedge clk) disable iff (rst)
        !(state == RUN && bus.iCacheRespValid));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(q_push && q_full));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: transaction-level model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mips_fetch_unit;
    import mips_fetch_pkg::*;

    localparam int          QDEPTH      = 4;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_HI = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_fetch_unit_if #(.XLEN(32)) bus ();
    mips_fetch_unit_if #(.XLEN(32)) bus_hi ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_stall, perf_flush;
    logic [31:0] hi_perf_fetch, hi_perf_stall, hi_perf_flush;
`endif

    mips_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_EN
        , .perfFetchCnt(perf_fetch), .perfStallCnt(perf_stall), .perfFlushCnt(perf_flush)
`endif
    );

    mips_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC_HI), .QDEPTH(QDEPTH)) u_dut_hi (
        .clk(clk),
        .rst(rst),
        .bus(bus_hi)
`ifdef FETCH_PERF_EN
        , .perfFetchCnt(hi_perf_fetch), .perfStallCnt(hi_perf_stall), .perfFlushCnt(hi_perf_flush)
`endif
    );

    // Reference model: the PC, whether a response is owed to us or is to be
    // thrown away, and the queue contents as a plain list.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } m_entry_t;
    m_entry_t    m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_perf_fetch, m_perf_stall, m_perf_flush;

    // ICache behaviour for the main DUT (random latency) and the wrap DUT (latency 1).
    bit ic_pending;
    int ic_resp_cyc;
    int k_ready_pct = 100;
    int k_lat_min   = 1;
    int k_lat_max   = 1;
    bit hi_pending;

    int          cyc = 0;
    int          rel_cyc = 0;
    int          first_fv_cyc = -1;
    logic [31:0] acc_log[$];
    logic [31:0] deq_log[$];
    logic [31:0] hi_acc_log[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit en, input bit fready, input bit redir, input logic [31:0] rpc);
        bus.fetchEn         = en;
        bus.iCacheReqReady  = ($urandom_range(99) < k_ready_pct);
        bus.iCacheRespValid = ic_pending && (cyc == ic_resp_cyc);
        bus.iCacheReadData  = $urandom();
        bus.fetchReady      = fready;
        bus.redirectValid   = redir;
        bus.redirectPc      = rpc;
        bus_hi.fetchEn         = 1'b1;
        bus_hi.iCacheReqReady  = 1'b1;
        bus_hi.iCacheRespValid = hi_pending;
        bus_hi.iCacheReadData  = $urandom();
        bus_hi.fetchReady      = 1'b1;
        bus_hi.redirectValid   = 1'b0;
        bus_hi.redirectPc      = '0;
    endtask

    // One clock: compare at the falling edge, advance model and ICache, then
    // return just after the next rising edge ready for new inputs.
    task automatic step();
        bit exp_req, exp_fv, outst, fire, pop;
        @(negedge clk);
        outst   = m_busy || m_drop;
        exp_req = !rst && bus.fetchEn && !outst && (m_q.size() < QDEPTH) && !bus.redirectValid;
        exp_fv  = !rst && (m_q.size() != 0) && !bus.redirectValid;
        check("req_valid", 32'(bus.iCacheReqValid), 32'(exp_req));
        check("fetch_valid", 32'(bus.fetchValid), 32'(exp_fv));
        if (!rst) check("req_addr", bus.iCacheReadAddr, m_pc);
        if (exp_fv) begin
            check("fetch_pc", bus.fetchPc, m_q[0].pc);
            check("fetch_instr", bus.fetchInstr, m_q[0].instr);
        end
`ifdef FETCH_PERF_EN
        if (!rst) begin
            check("perf_fetch", perf_fetch, m_perf_fetch);
            check("perf_stall", perf_stall, m_perf_stall);
            check("perf_flush", perf_flush, m_perf_flush);
        end
`endif
        if (!rst && bus.iCacheReqValid && bus.iCacheReqReady) acc_log.push_back(bus.iCacheReadAddr);
        if (!rst && bus.fetchValid && bus.fetchReady) deq_log.push_back(bus.fetchPc);
        if (!rst && bus.fetchValid && first_fv_cyc < 0) first_fv_cyc = cyc;
        if (!rst && bus_hi.iCacheReqValid && bus_hi.iCacheReqReady) hi_acc_log.push_back(bus_hi.iCacheReadAddr);

        if (rst) begin
            m_q.delete();
            m_pc = RESET_PC;
            m_req_pc = '0;
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_perf_fetch = '0;
            m_perf_stall = '0;
            m_perf_flush = '0;
        end else begin
            fire = exp_req && bus.iCacheReqReady;
            pop  = exp_fv && bus.fetchReady;
            if (!outst && bus.fetchEn && m_q.size() >= QDEPTH) m_perf_stall++;
            if (pop) void'(m_q.pop_front());
            if (bus.iCacheRespValid) begin
                if (m_busy && !bus.redirectValid) begin
                    m_q.push_back('{pc: m_req_pc, instr: bus.iCacheReadData});
                    m_perf_fetch++;
                end
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
            if (fire) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_busy   = 1'b1;
            end
            if (bus.redirectValid) begin
                m_q.delete();
                m_perf_flush++;
                if (m_busy) begin
                    m_busy = 1'b0;
                    m_drop = 1'b1;
                end
                m_pc = {bus.redirectPc[31:2], 2'b00};
            end
        end

        if (rst) begin
            ic_pending = 1'b0;
        end else begin
            if (bus.iCacheRespValid) ic_pending = 1'b0;
            if (bus.iCacheReqValid && bus.iCacheReqReady) begin
                ic_pending  = 1'b1;
                ic_resp_cyc = cyc + int'($urandom_range(k_lat_max, k_lat_min));
            end
        end
        hi_pending = !rst && bus_hi.iCacheReqValid && bus_hi.iCacheReqReady;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        deq_log.delete();
        hi_acc_log.delete();
        first_fv_cyc = -1;
        rel_cyc = cyc;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Streaming after reset with a 1-cycle ICache.
        k_ready_pct = 100; k_lat_min = 1; k_lat_max = 1;
        reset_dut();
        check("rst_addr", bus.iCacheReadAddr, RESET_PC);
        check("rst_fetch_pc", bus.fetchPc, 32'h0);
        check("rst_fetch_instr", bus.fetchInstr, 32'h0);
        check("rst_hi_addr", bus_hi.iCacheReadAddr, RESET_PC_HI);
        repeat (12) begin drive(1'b1, 1'b1, 1'b0, '0); step(); end
        check("stream_acc_n", acc_log.size(), 6);
        check("stream_acc0", acc_log[0], 32'h0);
        check("stream_acc1", acc_log[1], 32'h4);
        check("stream_acc2", acc_log[2], 32'h8);
        check("stream_deq_n", deq_log.size(), 5);
        check("stream_deq0", deq_log[0], 32'h0);
        check("stream_deq2", deq_log[2], 32'h8);
        check("stream_first_fv", first_fv_cyc - rel_cyc, 2);
        check("wrap_acc_n", hi_acc_log.size(), 6);
        check("wrap_acc0", hi_acc_log[0], 32'hFFFF_FFF8);
        check("wrap_acc1", hi_acc_log[1], 32'hFFFF_FFFC);
        check("wrap_acc2", hi_acc_log[2], 32'h0000_0000);

        // Decode stalled: the queue fills to exactly QDEPTH, then requests stop.
        reset_dut();
        repeat (16) begin drive(1'b1, 1'b0, 1'b0, '0); step(); end
        check("full_acc_n", acc_log.size(), 4);
        check("full_req_valid", 32'(bus.iCacheReqValid), 32'h0);
        check("full_deq_n", deq_log.size(), 0);
`ifdef FETCH_PERF_EN
        check("full_perf_stall", perf_stall, 32'd8);
        check("full_perf_fetch", perf_fetch, 32'd4);
`endif

        // Redirect to 0x1002 while waiting; the late response must be dropped.
        k_lat_min = 3; k_lat_max = 3;
        reset_dut();
        drive(1'b1, 1'b1, 1'b0, '0); step();
        drive(1'b1, 1'b1, 1'b1, 32'h1002); step();
        repeat (12) begin drive(1'b1, 1'b1, 1'b0, '0); step(); end
        check("drain_acc_n", acc_log.size(), 4);
        check("drain_acc1", acc_log[1], 32'h1000);
        check("drain_deq0", deq_log[0], 32'h1000);
        check("drain_first_fv", first_fv_cyc - rel_cyc, 8);

        // Redirect coincident with a response and with decode ready.
        k_lat_min = 1; k_lat_max = 1;
        reset_dut();
        repeat (3) begin drive(1'b1, 1'b0, 1'b0, '0); step(); end
        drive(1'b1, 1'b1, 1'b1, 32'h2000);
        #1;
        check("coinc_fetch_valid", 32'(bus.fetchValid), 32'h0);
        check("coinc_req_valid", 32'(bus.iCacheReqValid), 32'h0);
        step();
        repeat (6) begin drive(1'b1, 1'b1, 1'b0, '0); step(); end
        check("coinc_acc2", acc_log[2], 32'h2000);
        check("coinc_deq_n", deq_log.size(), 2);
        check("coinc_deq0", deq_log[0], 32'h2000);
`ifdef FETCH_PERF_EN
        check("coinc_perf_flush", perf_flush, 32'd1);
        check("coinc_perf_fetch", perf_fetch, 32'd4);
`endif

        // Reset while waiting, with the response landing in the reset cycle.
        reset_dut();
        drive(1'b1, 1'b1, 1'b0, '0); step();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, '0); step();
        rst = 1'b0;
        clear_logs();
        repeat (6) begin drive(1'b1, 1'b1, 1'b0, '0); step(); end
        check("rstwait_acc0", acc_log[0], RESET_PC);
        check("rstwait_first_fv", first_fv_cyc - rel_cyc, 2);
        check("rstwait_deq0", deq_log[0], RESET_PC);

        // Randomized traffic: back-pressure, variable latency, redirects, resets.
        k_ready_pct = 70; k_lat_min = 1; k_lat_max = 4;
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            bit          redir;
            redir = ($urandom_range(99) < 5);
            rpc   = ($urandom_range(9) == 0) ? 32'hFFFF_FFFE : $urandom();
            rst   = ($urandom_range(499) == 0);
            drive($urandom_range(99) < 85, $urandom_range(99) < 60, redir, rpc);
            step();
        end
        rst = 1'b0;
        check("rand_progress", 32'(deq_log.size() > 100), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
